// File: rtl/collision_response_unit.sv
// Single-edge collision response: reflects a vertex end position across an edge and
// rescales its tangential/normal velocity, using one shared iterative signed divider.
module collision_response_unit #(
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8,
   parameter int COEF_FRAC     = 4,
   parameter int COEF_SIZE     = 6,
   parameter int TAG_WIDTH     = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [TAG_WIDTH-1:0]     tag_in,
   input  logic [POSITION_SIZE-1:0] v1_x,
   input  logic [POSITION_SIZE-1:0] v1_y,
   input  logic [POSITION_SIZE-1:0] v2_x,
   input  logic [POSITION_SIZE-1:0] v2_y,
   input  logic [POSITION_SIZE-1:0] pos_x,
   input  logic [POSITION_SIZE-1:0] pos_y,
   input  logic [POSITION_SIZE-1:0] dx,
   input  logic [POSITION_SIZE-1:0] dy,
   input  logic [VELOCITY_SIZE-1:0] vel_x,
   input  logic [VELOCITY_SIZE-1:0] vel_y,
   input  logic [COEF_SIZE-1:0]     friction_in,
   input  logic [COEF_SIZE-1:0]     restitution_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TAG_WIDTH-1:0]     tag_out,
   output logic [POSITION_SIZE-1:0] x_new_out,
   output logic [POSITION_SIZE-1:0] y_new_out,
   output logic [VELOCITY_SIZE-1:0] vx_new_out,
   output logic [VELOCITY_SIZE-1:0] vy_new_out,
   output logic                     degenerate_out,
   output logic                     sat_out
);

   // state  | meaning
   // IDLE   | waiting for a request
   // SETUP  | registers qx/qy, |edge|^2 and the four signed numerators
   // DIV_P0 | x position correction quotient (load + DW iterations)
   // DIV_P1 | y position correction quotient
   // DIV_V0 | x velocity quotient
   // DIV_V1 | y velocity quotient
   // FINISH | clamps results and loads output registers
   // HOLD   | result presented until out_ready

   localparam int DW = 2*POSITION_SIZE + VELOCITY_SIZE + COEF_SIZE + 4;
   localparam int WW = DW + 2;
   localparam int CW = $clog2(DW + 1);

   localparam logic signed [WW-1:0] POS_MAX = WW'(2**(POSITION_SIZE-1) - 1);
   localparam logic signed [WW-1:0] POS_MIN = ~POS_MAX;
   localparam logic signed [WW-1:0] VEL_MAX = WW'(2**(VELOCITY_SIZE-1) - 1);
   localparam logic signed [WW-1:0] VEL_MIN = ~VEL_MAX;

   typedef enum logic [2:0] {
      IDLE, SETUP, DIV_P0, DIV_P1, DIV_V0, DIV_V1, FINISH, HOLD
   } state_t;

   state_t state, state_nx;

   logic [TAG_WIDTH-1:0]            tag_r;
   logic signed [POSITION_SIZE-1:0] v1x_r, v1y_r, v2x_r, v2y_r, posx_r, posy_r, dx_r, dy_r;
   logic signed [VELOCITY_SIZE-1:0] velx_r, vely_r;
   logic [COEF_SIZE-1:0]            fric_r, rest_r;

   logic signed [WW-1:0] qx_w, qy_w, rise_w, run_w, mag_w, c_w, vt_w, vn_w, ff_w, ee_w;
   logic signed [WW-1:0] np0_w, np1_w, nv0_w, nv1_w;

   logic signed [WW-1:0] qx_r, qy_r, mag_r, num_p0_r, num_p1_r, num_v0_r, num_v1_r;
   logic signed [WW-1:0] p0_r, p1_r, v0_r, v1_r;
   logic                 degenerate_r;

   logic signed [WW-1:0] num_sel, den_sel;
   logic [DW-1:0]        num_abs, den_abs;
   logic [DW-1:0]        dvd_r, dvs_r, rem_r;
   logic [DW:0]          rem_sh, rem_nx;
   logic [DW-1:0]        quo_nx;
   logic                 q_bit, neg_r;
   logic signed [WW-1:0] q_ext, q_res;
   logic [CW-1:0]        cnt_r;

   logic signed [WW-1:0] x_raw, y_raw, vx_raw, vy_raw, x_sat, y_sat, vx_sat, vy_sat;
   logic                 hit_x, hit_y, hit_vx, hit_vy;

   function automatic logic signed [WW-1:0] clamp(input logic signed [WW-1:0] v,
                                                  input logic signed [WW-1:0] lo,
                                                  input logic signed [WW-1:0] hi,
                                                  output logic hit);
      hit   = 1'b0;
      clamp = v;
      if (v > hi) begin
         clamp = hi;
         hit   = 1'b1;
      end else if (v < lo) begin
         clamp = lo;
         hit   = 1'b1;
      end
   endfunction

   // Everything is carried at WW bits so no intermediate product can overflow.
   assign qx_w   = WW'(posx_r) + WW'(dx_r);
   assign qy_w   = WW'(posy_r) + WW'(dy_r);
   assign rise_w = WW'(v2y_r) - WW'(v1y_r);
   assign run_w  = WW'(v2x_r) - WW'(v1x_r);
   assign mag_w  = run_w * run_w + rise_w * rise_w;
   assign c_w    = (qx_w - WW'(v1x_r)) * rise_w - (qy_w - WW'(v1y_r)) * run_w;
   assign vt_w   = WW'(velx_r) * run_w + WW'(vely_r) * rise_w;
   assign vn_w   = WW'(velx_r) * rise_w - WW'(vely_r) * run_w;
   assign ff_w   = $signed(WW'(fric_r));
   assign ee_w   = $signed(WW'(rest_r));
   assign np0_w  = (c_w <<< 1) * rise_w;
   assign np1_w  = (c_w <<< 1) * run_w;
   assign nv0_w  = vt_w * ff_w * run_w - vn_w * ee_w * rise_w;
   assign nv1_w  = vt_w * ff_w * rise_w + vn_w * ee_w * run_w;

   always_comb begin
      num_sel = num_p0_r;
      den_sel = mag_r;
      case (state)
         DIV_P1: num_sel = num_p1_r;
         DIV_V0: begin
            num_sel = num_v0_r;
            den_sel = mag_r <<< COEF_FRAC;
         end
         DIV_V1: begin
            num_sel = num_v1_r;
            den_sel = mag_r <<< COEF_FRAC;
         end
         default: ;
      endcase
   end

   assign num_abs = DW'(num_sel[WW-1] ? -num_sel : num_sel);
   assign den_abs = DW'(den_sel);

   // Restoring divider; quotient bits shift into the dividend register from the LSB.
   assign rem_sh = {rem_r, dvd_r[DW-1]};
   assign q_bit  = (rem_sh >= {1'b0, dvs_r});
   assign rem_nx = q_bit ? rem_sh - {1'b0, dvs_r} : rem_sh;
   assign quo_nx = {dvd_r[DW-2:0], q_bit};
   assign q_ext  = $signed({{(WW-DW){1'b0}}, quo_nx});
   assign q_res  = neg_r ? -q_ext : q_ext;

   always_comb begin
      hit_x  = 1'b0;
      hit_y  = 1'b0;
      hit_vx = 1'b0;
      hit_vy = 1'b0;
      x_raw  = qx_r - p0_r;
      y_raw  = qy_r + p1_r;
      vx_raw = v0_r;
      vy_raw = v1_r;
      if (degenerate_r) begin
         x_raw  = qx_r;
         y_raw  = qy_r;
         vx_raw = WW'(velx_r);
         vy_raw = WW'(vely_r);
      end
      x_sat  = clamp(x_raw,  POS_MIN, POS_MAX, hit_x);
      y_sat  = clamp(y_raw,  POS_MIN, POS_MAX, hit_y);
      vx_sat = clamp(vx_raw, VEL_MIN, VEL_MAX, hit_vx);
      vy_sat = clamp(vy_raw, VEL_MIN, VEL_MAX, hit_vy);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid && in_ready) state_nx = SETUP;
         SETUP:   state_nx = DIV_P0;
         DIV_P0:  if (cnt_r == '0) state_nx = DIV_P1;
         DIV_P1:  if (cnt_r == '0) state_nx = DIV_V0;
         DIV_V0:  if (cnt_r == '0) state_nx = DIV_V1;
         DIV_V1:  if (cnt_r == '0) state_nx = FINISH;
         FINISH:  state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         in_ready       <= 1'b0;
         out_valid      <= 1'b0;
         tag_out        <= '0;
         x_new_out      <= '0;
         y_new_out      <= '0;
         vx_new_out     <= '0;
         vy_new_out     <= '0;
         degenerate_out <= 1'b0;
         sat_out        <= 1'b0;
         tag_r          <= '0;
         v1x_r          <= '0;
         v1y_r          <= '0;
         v2x_r          <= '0;
         v2y_r          <= '0;
         posx_r         <= '0;
         posy_r         <= '0;
         dx_r           <= '0;
         dy_r           <= '0;
         velx_r         <= '0;
         vely_r         <= '0;
         fric_r         <= '0;
         rest_r         <= '0;
         qx_r           <= '0;
         qy_r           <= '0;
         mag_r          <= '0;
         num_p0_r       <= '0;
         num_p1_r       <= '0;
         num_v0_r       <= '0;
         num_v1_r       <= '0;
         degenerate_r   <= 1'b0;
         p0_r           <= '0;
         p1_r           <= '0;
         v0_r           <= '0;
         v1_r           <= '0;
         dvd_r          <= '0;
         dvs_r          <= '0;
         rem_r          <= '0;
         neg_r          <= 1'b0;
         cnt_r          <= '0;
      end else begin
         in_ready <= (state_nx == IDLE);
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  tag_r  <= tag_in;
                  v1x_r  <= $signed(v1_x);
                  v1y_r  <= $signed(v1_y);
                  v2x_r  <= $signed(v2_x);
                  v2y_r  <= $signed(v2_y);
                  posx_r <= $signed(pos_x);
                  posy_r <= $signed(pos_y);
                  dx_r   <= $signed(dx);
                  dy_r   <= $signed(dy);
                  velx_r <= $signed(vel_x);
                  vely_r <= $signed(vel_y);
                  fric_r <= friction_in;
                  rest_r <= restitution_in;
               end
            end
            SETUP: begin
               qx_r         <= qx_w;
               qy_r         <= qy_w;
               mag_r        <= mag_w;
               num_p0_r     <= np0_w;
               num_p1_r     <= np1_w;
               num_v0_r     <= nv0_w;
               num_v1_r     <= nv1_w;
               degenerate_r <= (mag_w == '0);
               cnt_r        <= CW'(DW);
            end
            DIV_P0, DIV_P1, DIV_V0, DIV_V1: begin
               if (cnt_r == CW'(DW)) begin
                  // A zero-length edge has all-zero numerators; divisor 1 keeps the quotient 0.
                  dvd_r <= num_abs;
                  dvs_r <= degenerate_r ? DW'(1) : den_abs;
                  rem_r <= '0;
                  neg_r <= num_sel[WW-1];
                  cnt_r <= cnt_r - CW'(1);
               end else begin
                  rem_r <= DW'(rem_nx);
                  dvd_r <= quo_nx;
                  if (cnt_r == '0) begin
                     cnt_r <= CW'(DW);
                     case (state)
                        DIV_P0:  p0_r <= q_res;
                        DIV_P1:  p1_r <= q_res;
                        DIV_V0:  v0_r <= q_res;
                        default: v1_r <= q_res;
                     endcase
                  end else begin
                     cnt_r <= cnt_r - CW'(1);
                  end
               end
            end
            FINISH: begin
               out_valid      <= 1'b1;
               tag_out        <= tag_r;
               x_new_out      <= POSITION_SIZE'(x_sat);
               y_new_out      <= POSITION_SIZE'(y_sat);
               vx_new_out     <= VELOCITY_SIZE'(vx_sat);
               vy_new_out     <= VELOCITY_SIZE'(vy_sat);
               degenerate_out <= degenerate_r;
               sat_out        <= hit_x | hit_y | hit_vx | hit_vy;
            end
            HOLD: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/collision_response_unit.md
Name: collision_response_unit

Overview:
- Parametrised successor to the single-edge collision solver in the squishy-car physics pipeline.
- Takes one body vertex that has crossed a polygon edge. Reflects its projected end position across the edge line, and decomposes its velocity into tangential and normal parts, each scaled by a programmable coefficient.
- Uses one shared iterative signed divider, time-multiplexed over four quotients.
- Has a valid/ready handshake on both sides and a tag that is passed through, so many vertices can be streamed through one instance.

Parameters:
- POSITION_SIZE, 8, signed position width.
- VELOCITY_SIZE, 8, signed velocity width.
- COEF_FRAC, 4, fractional bits of the friction/restitution coefficients (unsigned Q(COEF_FRAC)).
- COEF_SIZE, 6, total width of the coefficient inputs.
- TAG_WIDTH, 4, width of the pass-through vertex tag.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- tag_in  input  TAG_WIDTH  vertex id, returned unchanged
- v1_x, v1_y, v2_x, v2_y  input  POSITION_SIZE each  edge endpoints, signed
- pos_x, pos_y  input  POSITION_SIZE each  vertex start position, signed
- dx, dy  input  POSITION_SIZE each  displacement this step, signed
- vel_x, vel_y  input  VELOCITY_SIZE each  vertex velocity, signed
- friction_in  input  COEF_SIZE  tangential retention coefficient (1.0 = 2^COEF_FRAC)
- restitution_in  input  COEF_SIZE  normal retention coefficient
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- tag_out  output  TAG_WIDTH  captured tag
- x_new_out, y_new_out  output  POSITION_SIZE each  corrected position
- vx_new_out, vy_new_out  output  VELOCITY_SIZE each  corrected velocity
- degenerate_out  output  1  edge had zero length; results are pass-through
- sat_out  output  1  at least one output field was saturated

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE; in_ready=0 while reset is asserted, 1 on the first cycle after release; out_valid=0; all data outputs, tag_out and flags = 0. Reset during any state aborts the operation with no output.
- Accept: on a rising edge with in_valid && in_ready, capture all inputs, go to SETUP. in_ready = (state==IDLE) && !out_valid.
- Arithmetic, all full precision with no intermediate overflow:
  - qx=pos_x+dx, qy=pos_y+dy
  - rise=v2_y-v1_y, run=v2_x-v1_x, mag=run^2+rise^2
  - c=(qx-v1_x)*rise-(qy-v1_y)*run
  - vt=vel_x*run+vel_y*rise, vn=vel_x*rise-vel_y*run
  - F=friction_in, E=restitution_in
- Quotients:
  - P0 = (2c*rise)/mag
  - P1 = (2c*run)/mag
  - V0 = (vt*F*run - vn*E*rise)/(mag<<COEF_FRAC)
  - V1 = (vt*F*rise + vn*E*run)/(mag<<COEF_FRAC)
- Results: x_new=qx-P0, y_new=qy+P1, vx_new=V0, vy_new=V1.
- Division is signed, truncates toward zero, and runs on magnitudes with the sign applied afterwards. DW = 2*POSITION_SIZE+VELOCITY_SIZE+COEF_SIZE+4 (localparam); each division takes 1 load cycle plus DW iteration cycles, one quotient bit per cycle.
- States and transitions:
  - IDLE -> SETUP (1 cycle, registers products).
  - SETUP -> DIV_P0 -> DIV_P1 -> DIV_V0 -> DIV_V1 -> FINISH, each DIV state lasting DW+1 cycles.
  - FINISH (1 cycle) saturates the results and loads the outputs, then -> HOLD.
- Latency: out_valid rises exactly 4*(DW+1)+2 cycles after the accept edge. This is fixed, including the degenerate case.
- Saturation: each result is clamped to its signed output range. sat_out=1 if any clamp occurred.
- Degenerate edge (mag==0): divisions are skipped but states are still timed identically. Outputs are x_new=qx, y_new=qy, vx=vel_x, vy=vel_y (sign-extended or truncated) with degenerate_out=1, never X and never divide-by-zero.
- HOLD: out_valid=1 and all outputs stable until out_valid && out_ready. On that edge out_valid->0 and state->IDLE, so in_ready rises the following cycle; at most one request is in flight.
- in_valid asserted while in_ready=0 is ignored; no input is captured. The source must hold its data until accepted.
- Coefficient values above 1.0 are legal; the results simply saturate where needed.

Test Plan:
- Edge (0,0)-(10,0), pos (3,2), d (0,-4), vel (5,-6), F=E=16, out_ready=1 -> x_new=3, y_new=2, vx=5, vy=6, flags 0, out_valid exactly 4*(DW+1)+2 cycles after accept.
- Same stimulus with E=8 (0.5), F=16 -> vx=5, vy=3. With F=0, E=16 -> vx=0, vy=6.
- Zero-length edge (4,4)-(4,4), pos (1,1), d (2,3), vel (-7,2) -> x_new=3, y_new=4, vx=-7, vy=2, degenerate_out=1, same latency.
- Edge (0,0)-(1,0), pos (0,100), d (0,27), vel (0,-120), E=32 (2.0) -> vy saturates to 127, sat_out=1.
- out_ready held low 20 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is ignored; after the out_ready pulse the second request is accepted and completes with the correct tag.
- rst_in pulsed low during DIV_V0 -> out_valid stays 0, outputs 0; a new request afterwards completes correctly.
